// File: rtl/cpu_controller.sv
// Multi-cycle Moore controller for the Simple RISC Machine: fetch/decode/execute
// sequencing with a bounded memory-ready wait, optional branches and illegal-op trapping.
module cpu_controller #(
  parameter int WAIT_W     = 4,
  parameter int WAIT_LIMIT = 15,
  parameter bit BRANCH_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted,
  output logic       mem_err,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
    S_ALU_A, S_ALU_B, S_ALU_C, S_WB_C,
    S_CMP_A, S_CMP_B, S_CMP_S,
    S_MOV_B, S_MOV_C, S_MOVI,
    S_LDR_A, S_LDR_C, S_LDR_ADDR, S_LDR_RD, S_LDR_WB,
    S_STR_A, S_STR_C, S_STR_ADDR, S_STR_B, S_STR_C2, S_STR_WR,
    S_BR, S_LINK, S_BX,
    S_HALT, S_ILLEGAL, S_MEMERR
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_mem_state;
  logic                w_wait_hit;

  function automatic logic cond_true(input logic [2:0] c, input logic n, input logic v,
                                     input logic z);
    logic t;
    case (c)
      3'b000:  t = 1'b1;
      3'b001:  t = z;
      3'b010:  t = ~z;
      3'b011:  t = n ^ v;
      3'b100:  t = (n ^ v) | z;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Anything not explicitly recognised here lands in ILLEGAL.
  function automatic state_t decode_next(input logic [2:0] opc, input logic [1:0] opf,
                                         input logic [2:0] c, input logic n,
                                         input logic v, input logic z);
    state_t nxt;
    nxt = S_ILLEGAL;
    case (opc)
      3'b101: begin
        case (opf)
          2'b00:   nxt = S_ALU_A;
          2'b01:   nxt = S_CMP_A;
          2'b10:   nxt = S_ALU_A;
          2'b11:   nxt = S_MOV_B;
          default: nxt = S_ILLEGAL;
        endcase
      end
      3'b110: begin
        if (opf == 2'b00) nxt = S_MOV_B;
        else if (opf == 2'b10) nxt = S_MOVI;
        else nxt = S_ILLEGAL;
      end
      3'b011: begin
        if (opf == 2'b00) nxt = S_LDR_A;
        else nxt = S_ILLEGAL;
      end
      3'b100: begin
        if (opf == 2'b00) nxt = S_STR_A;
        else nxt = S_ILLEGAL;
      end
      3'b001: begin
        if (BRANCH_EN && (opf == 2'b00) && (c <= 3'b100))
          nxt = cond_true(c, n, v, z) ? S_BR : S_IF1;
        else
          nxt = S_ILLEGAL;
      end
      3'b010: begin
        if (!BRANCH_EN) nxt = S_ILLEGAL;
        else if (opf == 2'b11) nxt = S_LINK;
        else if (opf == 2'b00) nxt = S_BX;
        else nxt = S_ILLEGAL;
      end
      3'b111:  nxt = S_HALT;
      default: nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  assign w_mem_state = (r_state == S_IF1) || (r_state == S_LDR_RD) || (r_state == S_STR_WR);
  assign w_wait_hit  = (r_wait == WAIT_W'(WAIT_LIMIT));

  // State register and wait counter; the counter restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_wait  <= {WAIT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_wait <= {WAIT_W{1'b0}};
      else if (w_mem_state && !mem_ready)
        r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
      else
        r_wait <= r_wait;
    end
  end

  // Next-state logic; ready wins over the timeout on the limit cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET:     w_next_state = S_IF1;
      S_IF1: begin
        if (mem_ready) w_next_state = S_IF2;
        else if (w_wait_hit) w_next_state = S_MEMERR;
        else w_next_state = S_IF1;
      end
      S_IF2:       w_next_state = S_UPDATE_PC;
      S_UPDATE_PC: w_next_state = S_DECODE;
      S_DECODE:    w_next_state = decode_next(opcode, op, cond, N, V, Z);
      S_ALU_A:     w_next_state = S_ALU_B;
      S_ALU_B:     w_next_state = S_ALU_C;
      S_ALU_C:     w_next_state = S_WB_C;
      S_WB_C:      w_next_state = S_IF1;
      S_CMP_A:     w_next_state = S_CMP_B;
      S_CMP_B:     w_next_state = S_CMP_S;
      S_CMP_S:     w_next_state = S_IF1;
      S_MOV_B:     w_next_state = S_MOV_C;
      S_MOV_C:     w_next_state = S_WB_C;
      S_MOVI:      w_next_state = S_IF1;
      S_LDR_A:     w_next_state = S_LDR_C;
      S_LDR_C:     w_next_state = S_LDR_ADDR;
      S_LDR_ADDR:  w_next_state = S_LDR_RD;
      S_LDR_RD: begin
        if (mem_ready) w_next_state = S_LDR_WB;
        else if (w_wait_hit) w_next_state = S_MEMERR;
        else w_next_state = S_LDR_RD;
      end
      S_LDR_WB:    w_next_state = S_IF1;
      S_STR_A:     w_next_state = S_STR_C;
      S_STR_C:     w_next_state = S_STR_ADDR;
      S_STR_ADDR:  w_next_state = S_STR_B;
      S_STR_B:     w_next_state = S_STR_C2;
      S_STR_C2:    w_next_state = S_STR_WR;
      S_STR_WR: begin
        if (mem_ready) w_next_state = S_IF1;
        else if (w_wait_hit) w_next_state = S_MEMERR;
        else w_next_state = S_STR_WR;
      end
      S_BR:        w_next_state = S_IF1;
      S_LINK:      w_next_state = S_BR;
      S_BX:        w_next_state = S_IF1;
      S_HALT:      w_next_state = S_HALT;
      S_ILLEGAL:   w_next_state = S_ILLEGAL;
      S_MEMERR:    w_next_state = S_MEMERR;
      default:     w_next_state = S_RESET;
    endcase
  end

  // Moore output decode from the present state only.
  always_comb begin
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    pc_sel    = 2'b00;
    mem_cmd   = 2'b00;
    nsel      = 3'b000;
    vsel      = 4'b0000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    mem_err   = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_RESET: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        pc_sel  = 2'b00;
      end
      S_DECODE: begin
      end
      S_ALU_A, S_CMP_A, S_LDR_A, S_STR_A: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_ALU_B, S_CMP_B, S_MOV_B: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_ALU_C: loadc = 1'b1;
      S_WB_C: begin
        write = 1'b1;
        nsel  = 3'b010;
        vsel  = 4'b0001;
      end
      S_CMP_S: loads = 1'b1;
      S_MOV_C, S_STR_C2: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MOVI: begin
        write = 1'b1;
        nsel  = 3'b100;
        vsel  = 4'b0100;
      end
      S_LDR_C, S_STR_C: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LDR_ADDR, S_STR_ADDR: load_addr = 1'b1;
      S_LDR_RD: begin
        mem_cmd  = 2'b01;
        addr_sel = 1'b0;
      end
      S_LDR_WB: begin
        write = 1'b1;
        nsel  = 3'b010;
        vsel  = 4'b1000;
      end
      S_STR_B: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_STR_WR: mem_cmd = 2'b10;
      S_BR: begin
        load_pc = 1'b1;
        pc_sel  = 2'b01;
      end
      S_LINK: begin
        write = 1'b1;
        nsel  = 3'b100;
        vsel  = 4'b0010;
      end
      S_BX: begin
        nsel    = 3'b010;
        load_pc = 1'b1;
        pc_sel  = 2'b10;
      end
      S_HALT: halted = 1'b1;
      S_ILLEGAL: begin
        illegal = 1'b1;
        halted  = 1'b1;
      end
      S_MEMERR: begin
        mem_err = 1'b1;
        halted  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller; outputs are packed into one
// vector per instance and compared against hand-built per-state expectations.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] cond = 3'b000;
  logic       n_f = 1'b0, v_f = 1'b0, z_f = 1'b0;
  logic       mem_ready = 1'b1;

  logic load_ir, load_pc, reset_pc, addr_sel, load_addr;
  logic [1:0] pc_sel, mem_cmd;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic write, loada, loadb, loadc, loads, asel, bsel, halted, mem_err, illegal;

  logic nb_load_ir, nb_load_pc, nb_reset_pc, nb_addr_sel, nb_load_addr;
  logic [1:0] nb_pc_sel, nb_mem_cmd;
  logic [2:0] nb_nsel;
  logic [3:0] nb_vsel;
  logic nb_write, nb_loada, nb_loadb, nb_loadc, nb_loads, nb_asel, nb_bsel;
  logic nb_halted, nb_mem_err, nb_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(n_f), .V(v_f), .Z(z_f), .mem_ready(mem_ready),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
    .load_addr(load_addr), .pc_sel(pc_sel), .mem_cmd(mem_cmd), .nsel(nsel), .vsel(vsel),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .halted(halted), .mem_err(mem_err), .illegal(illegal)
  );

  cpu_controller #(.BRANCH_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(n_f), .V(v_f), .Z(z_f), .mem_ready(mem_ready),
    .load_ir(nb_load_ir), .load_pc(nb_load_pc), .reset_pc(nb_reset_pc),
    .addr_sel(nb_addr_sel), .load_addr(nb_load_addr), .pc_sel(nb_pc_sel),
    .mem_cmd(nb_mem_cmd), .nsel(nb_nsel), .vsel(nb_vsel), .write(nb_write),
    .loada(nb_loada), .loadb(nb_loadb), .loadc(nb_loadc), .loads(nb_loads),
    .asel(nb_asel), .bsel(nb_bsel), .halted(nb_halted), .mem_err(nb_mem_err),
    .illegal(nb_illegal)
  );

  wire [25:0] obs = {load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel, mem_cmd,
                     nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                     halted, mem_err, illegal};
  wire [25:0] obs_nb = {nb_load_ir, nb_load_pc, nb_reset_pc, nb_addr_sel, nb_load_addr,
                        nb_pc_sel, nb_mem_cmd, nb_nsel, nb_vsel, nb_write, nb_loada,
                        nb_loadb, nb_loadc, nb_loads, nb_asel, nb_bsel, nb_halted,
                        nb_mem_err, nb_illegal};

  // Single-field masks, bit positions follow the packing of obs.
  localparam logic [25:0] M_ILL = 26'h1, M_MERR = 26'h2, M_HALT = 26'h4, M_BSEL = 26'h8;
  localparam logic [25:0] M_ASEL = 26'h10, M_LS = 26'h20, M_LC = 26'h40, M_LB = 26'h80;
  localparam logic [25:0] M_LA = 26'h100, M_WR = 26'h200;
  localparam logic [25:0] V_C = 26'h400, V_PC = 26'h800, V_IMM = 26'h1000, V_MD = 26'h2000;
  localparam logic [25:0] NS_RM = 26'h4000, NS_RD = 26'h8000, NS_RN = 26'h10000;
  localparam logic [25:0] MC_RD = 26'h20000, MC_WR = 26'h40000;
  localparam logic [25:0] PC_01 = 26'h80000, PC_10 = 26'h100000;
  localparam logic [25:0] M_LDADDR = 26'h200000, M_ADDRSEL = 26'h400000;
  localparam logic [25:0] M_RSTPC = 26'h800000, M_LDPC = 26'h1000000, M_LDIR = 26'h2000000;

  localparam logic [25:0] E_RESET = M_LDPC | M_RSTPC;
  localparam logic [25:0] E_IF1   = M_ADDRSEL | MC_RD;
  localparam logic [25:0] E_IF2   = M_ADDRSEL | MC_RD | M_LDIR;
  localparam logic [25:0] E_UPD   = M_LDPC;
  localparam logic [25:0] E_DEC   = 26'h0;
  localparam logic [25:0] E_A     = NS_RN | M_LA;
  localparam logic [25:0] E_B     = NS_RM | M_LB;
  localparam logic [25:0] E_C     = M_LC;
  localparam logic [25:0] E_D     = M_WR | NS_RD | V_C;
  localparam logic [25:0] E_S     = M_LS;
  localparam logic [25:0] E_CA    = M_ASEL | M_LC;
  localparam logic [25:0] E_CB    = M_BSEL | M_LC;
  localparam logic [25:0] E_ADDR  = M_LDADDR;
  localparam logic [25:0] E_RD    = MC_RD;
  localparam logic [25:0] E_WB    = M_WR | NS_RD | V_MD;
  localparam logic [25:0] E_SB    = NS_RD | M_LB;
  localparam logic [25:0] E_WRM   = MC_WR;
  localparam logic [25:0] E_MOVI  = M_WR | NS_RN | V_IMM;
  localparam logic [25:0] E_BR    = M_LDPC | PC_01;
  localparam logic [25:0] E_LINK  = M_WR | NS_RN | V_PC;
  localparam logic [25:0] E_BX    = NS_RD | M_LDPC | PC_10;
  localparam logic [25:0] E_HALT  = M_HALT;
  localparam logic [25:0] E_ILL   = M_HALT | M_ILL;
  localparam logic [25:0] E_MERR  = M_HALT | M_MERR;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in their first IF1 cycle with mem_ready high.
  task automatic apply_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== E_RESET) begin
      bad++; $display("FAIL reset_async: got %h expected %h", obs, E_RESET);
    end
    total++;
    if (obs_nb !== E_RESET) begin
      bad++; $display("FAIL reset_async_nb: got %h expected %h", obs_nb, E_RESET);
    end
    step();
    step();
    total++;
    if (obs !== E_RESET) begin
      bad++; $display("FAIL reset_hold: got %h expected %h", obs, E_RESET);
    end
    reset = 1'b1;
    step();
    total++;
    if (obs !== E_IF1) begin
      bad++; $display("FAIL reset_to_if1: got %h expected %h", obs, E_IF1);
    end
  endtask

  task automatic test_alu();
    logic [25:0] s [10];
    int n;
    string nm;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      case (t)
        0: begin nm = "ADD"; opcode = 3'b101; op = 2'b00; n = 8;
           s = '{E_IF2, E_UPD, E_DEC, E_A, E_B, E_C, E_D, E_IF1, E_DEC, E_DEC}; end
        1: begin nm = "AND"; opcode = 3'b101; op = 2'b10; n = 8;
           s = '{E_IF2, E_UPD, E_DEC, E_A, E_B, E_C, E_D, E_IF1, E_DEC, E_DEC}; end
        2: begin nm = "CMP"; opcode = 3'b101; op = 2'b01; n = 7;
           s = '{E_IF2, E_UPD, E_DEC, E_A, E_B, E_S, E_IF1, E_DEC, E_DEC, E_DEC}; end
        3: begin nm = "MVN"; opcode = 3'b101; op = 2'b11; n = 7;
           s = '{E_IF2, E_UPD, E_DEC, E_B, E_CA, E_D, E_IF1, E_DEC, E_DEC, E_DEC}; end
        4: begin nm = "MOVR"; opcode = 3'b110; op = 2'b00; n = 7;
           s = '{E_IF2, E_UPD, E_DEC, E_B, E_CA, E_D, E_IF1, E_DEC, E_DEC, E_DEC}; end
        default: begin nm = "MOVI"; opcode = 3'b110; op = 2'b10; n = 5;
           s = '{E_IF2, E_UPD, E_DEC, E_MOVI, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
      endcase
      apply_reset();
      total++;
      if (obs !== E_IF1) begin
        bad++; $display("FAIL %s start: got %h expected %h", nm, obs, E_IF1);
      end
      for (int k = 0; k < n; k++) begin
        step();
        total++;
        if (obs !== s[k]) begin
          bad++; $display("FAIL %s step%0d: got %h expected %h", nm, k, obs, s[k]);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [25:0] s [10];
    opcode = 3'b011; op = 2'b00;
    s = '{E_IF2, E_UPD, E_DEC, E_A, E_CB, E_ADDR, E_RD, E_DEC, E_DEC, E_DEC};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if (obs !== s[k]) begin
        bad++; $display("FAIL LDR step%0d: got %h expected %h", k, obs, s[k]);
      end
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (obs !== E_RD) begin
        bad++; $display("FAIL LDR rd_wait%0d: got %h expected %h", k, obs, E_RD);
      end
    end
    mem_ready = 1'b1;
    step();
    total++;
    if (obs !== E_WB) begin
      bad++; $display("FAIL LDR wb: got %h expected %h", obs, E_WB);
    end
    step();
    total++;
    if (obs !== E_IF1) begin
      bad++; $display("FAIL LDR done: got %h expected %h", obs, E_IF1);
    end
    opcode = 3'b100; op = 2'b00;
    s = '{E_IF2, E_UPD, E_DEC, E_A, E_CB, E_ADDR, E_SB, E_CA, E_WRM, E_IF1};
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (obs !== s[k]) begin
        bad++; $display("FAIL STR step%0d: got %h expected %h", k, obs, s[k]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    opcode = 3'b110; op = 2'b10;
    apply_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (obs !== E_IF1) begin
        bad++; $display("FAIL fetch_wait%0d: got %h expected %h", k, obs, E_IF1);
      end
    end
    mem_ready = 1'b1;
    step();
    total++;
    if (obs !== E_IF2) begin
      bad++; $display("FAIL fetch_wait_if2: got %h expected %h", obs, E_IF2);
    end
  endtask

  task automatic test_mem_timeout();
    for (int t = 0; t < 2; t++) begin
      opcode = 3'b011; op = 2'b00;
      apply_reset();
      for (int k = 0; k < 7; k++) step();
      total++;
      if (obs !== E_RD) begin
        bad++; $display("FAIL timeout%0d reach_rd: got %h expected %h", t, obs, E_RD);
      end
      mem_ready = 1'b0;
      for (int k = 0; k < 15; k++) begin
        step();
        total++;
        if (obs !== E_RD) begin
          bad++; $display("FAIL timeout%0d hold%0d: got %h expected %h", t, k, obs, E_RD);
        end
      end
      if (t == 0) begin
        step();
        total++;
        if (obs !== E_MERR) begin
          bad++; $display("FAIL timeout memerr: got %h expected %h", obs, E_MERR);
        end
        for (int k = 0; k < 3; k++) step();
        total++;
        if (obs !== E_MERR) begin
          bad++; $display("FAIL timeout sticky: got %h expected %h", obs, E_MERR);
        end
        apply_reset();
        total++;
        if (obs !== E_IF1) begin
          bad++; $display("FAIL timeout recover: got %h expected %h", obs, E_IF1);
        end
        step();
        total++;
        if (obs !== E_IF2) begin
          bad++; $display("FAIL timeout refetch: got %h expected %h", obs, E_IF2);
        end
      end else begin
        mem_ready = 1'b1;
        step();
        total++;
        if (obs !== E_WB) begin
          bad++; $display("FAIL ready_wins: got %h expected %h", obs, E_WB);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [25:0] s [10];
    int n;
    for (int t = 0; t < 10; t++) begin
      opcode = 3'b001; op = 2'b00; cond = 3'b000;
      n_f = 1'b0; v_f = 1'b0; z_f = 1'b0;
      s = '{E_IF2, E_UPD, E_DEC, E_BR, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC};
      n = 5;
      case (t)
        0: cond = 3'b000;
        1: begin cond = 3'b001; z_f = 1'b1; end
        2: begin cond = 3'b001; n = 4;
           s = '{E_IF2, E_UPD, E_DEC, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
        3: begin cond = 3'b010; z_f = 1'b1; n = 4;
           s = '{E_IF2, E_UPD, E_DEC, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
        4: begin cond = 3'b011; n_f = 1'b1; end
        5: begin cond = 3'b011; n_f = 1'b1; v_f = 1'b1; n = 4;
           s = '{E_IF2, E_UPD, E_DEC, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
        6: begin cond = 3'b100; z_f = 1'b1; end
        7: begin opcode = 3'b010; op = 2'b11; n = 6;
           s = '{E_IF2, E_UPD, E_DEC, E_LINK, E_BR, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC}; end
        8: begin opcode = 3'b010; op = 2'b00;
           s = '{E_IF2, E_UPD, E_DEC, E_BX, E_IF1, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
        default: begin cond = 3'b101;
           s = '{E_IF2, E_UPD, E_DEC, E_ILL, E_ILL, E_DEC, E_DEC, E_DEC, E_DEC, E_DEC}; end
      endcase
      apply_reset();
      for (int k = 0; k < n; k++) begin
        step();
        total++;
        if (obs !== s[k]) begin
          bad++; $display("FAIL branch%0d step%0d: got %h expected %h", t, k, obs, s[k]);
        end
      end
    end
  endtask

  task automatic test_branch_disabled();
    opcode = 3'b001; op = 2'b00; cond = 3'b000;
    apply_reset();
    for (int k = 0; k < 3; k++) step();
    total++;
    if (obs_nb !== E_DEC) begin
      bad++; $display("FAIL nobranch decode: got %h expected %h", obs_nb, E_DEC);
    end
    step();
    total++;
    if (obs_nb !== E_ILL) begin
      bad++; $display("FAIL nobranch illegal: got %h expected %h", obs_nb, E_ILL);
    end
    total++;
    if (obs !== E_BR) begin
      bad++; $display("FAIL branch_en taken: got %h expected %h", obs, E_BR);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (obs_nb !== E_ILL) begin
        bad++; $display("FAIL nobranch sticky%0d: got %h expected %h", k, obs_nb, E_ILL);
      end
    end
  endtask

  task automatic test_illegal_halt();
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: begin opcode = 3'b000; op = 2'b00; end
        1: begin opcode = 3'b110; op = 2'b01; end
        2: begin opcode = 3'b011; op = 2'b10; end
        3: begin opcode = 3'b100; op = 2'b11; end
        4: begin opcode = 3'b010; op = 2'b01; end
        default: begin opcode = 3'b111; op = 2'b00; end
      endcase
      apply_reset();
      for (int k = 0; k < 4; k++) step();
      total++;
      if (obs !== ((t == 5) ? E_HALT : E_ILL)) begin
        bad++; $display("FAIL trap%0d entry: got %h expected %h", t, obs,
                        (t == 5) ? E_HALT : E_ILL);
      end
      for (int k = 0; k < 4; k++) step();
      total++;
      if (obs !== ((t == 5) ? E_HALT : E_ILL)) begin
        bad++; $display("FAIL trap%0d sticky: got %h expected %h", t, obs,
                        (t == 5) ? E_HALT : E_ILL);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== E_RESET) begin
      bad++; $display("FAIL halt_reset: got %h expected %h", obs, E_RESET);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_wr();
    opcode = 3'b100; op = 2'b00;
    apply_reset();
    for (int k = 0; k < 9; k++) step();
    total++;
    if (obs !== E_WRM) begin
      bad++; $display("FAIL midwr reach: got %h expected %h", obs, E_WRM);
    end
    mem_ready = 1'b0;
    step();
    step();
    total++;
    if (obs !== E_WRM) begin
      bad++; $display("FAIL midwr hold: got %h expected %h", obs, E_WRM);
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== E_RESET) begin
      bad++; $display("FAIL midwr async_reset: got %h expected %h", obs, E_RESET);
    end
    step();
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    total++;
    if (obs !== E_IF1) begin
      bad++; $display("FAIL midwr restart: got %h expected %h", obs, E_IF1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_fetch_wait();
    test_mem_timeout();
    test_branch();
    test_branch_disabled();
    test_illegal_halt();
    test_reset_mid_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
